// File: rtl/wb_classic_uart.sv
// Wishbone classic (B3) slave with a UART and 16-entry RX/TX FIFOs, UART-lite register map.
// Offsets: 0x0 RX pop, 0x4 TX push, 0x8 status (clear-on-read errors), 0xC control (FIFO resets).

module wb_classic_uart_dly #(
    parameter int   STAGES  = 0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    generate
        if (STAGES == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ rst;
            assign q = d;
        end else begin : g_pipe
            logic [STAGES-1:0] stage_q;
            logic [STAGES-1:0] stage_d;

            always_comb begin
                stage_d[0] = d;
                for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
            end

            // NOTE: state flops use <= so every flop samples pre-edge values, independent of block order.
            always_ff @(posedge clk) begin
                if (!rst) stage_q <= {STAGES{RST_VAL}};
                else      stage_q <= stage_d;
            end

            assign q = stage_q[STAGES-1];
        end
    endgenerate
endmodule

module wb_classic_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pop_ok   = pop && !empty_q;
        push_ok  = push && (!full_q || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
endmodule

module wb_classic_uart #(
    parameter int BAUD_CLOCK_SPEED = 2000000,
    parameter int BAUD_RATE        = 115200,
    parameter int PARITY_ENA       = 0,
    parameter int PARITY_TYPE      = 0,
    parameter int STOP_BITS        = 1,
    parameter int DATA_BITS        = 8,
    parameter int RX_DELAY         = 0,
    parameter int RX_BAUD_DELAY    = 0,
    parameter int TX_DELAY         = 0,
    parameter int TX_BAUD_DELAY    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_wb_cyc,
    input  logic        s_wb_stb,
    input  logic        s_wb_we,
    input  logic [15:0] s_wb_addr,
    input  logic [31:0] s_wb_data_i,
    input  logic [3:0]  s_wb_sel,
    output logic        s_wb_ack,
    output logic [31:0] s_wb_data_o,
    output logic        tx,
    input  logic        rx,
    output logic        rts,
    input  logic        cts
);
    localparam int BIT_PERIOD  = BAUD_CLOCK_SPEED / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int DB          = DATA_BITS;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} frame_state_e;

    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          overrun_q, overrun_d, frame_q, frame_d, parity_q, parity_d;
    logic          req, status_rd;
    logic [31:0]   status;

    logic          tx_push, tx_full, tx_empty, tx_launch;
    logic [DB-1:0] tx_rdata;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [DB-1:0] rx_rdata;

    frame_state_e  tx_state_q, tx_state_d;
    logic [15:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic          tx_stop_q, tx_stop_d, tx_par_q, tx_par_d, tx_line_q, tx_line_d;
    logic [DB-1:0] tx_shift_q, tx_shift_d;
    logic          tx_tick_raw, tx_tick;

    logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d, rx_in;
    frame_state_e  rx_state_q, rx_state_d;
    logic [15:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic          rx_par_bad_q, rx_par_bad_d;
    logic [DB-1:0] rx_shift_q, rx_shift_d;
    logic          rx_tick_raw, rx_tick;

    logic unused_bits;
    assign unused_bits = ^{s_wb_sel, s_wb_addr[15:4], s_wb_addr[1:0], s_wb_data_i};

    wb_classic_uart_fifo #(.WIDTH(DB), .DEPTH(16)) u_tx_fifo (
        .clk(clk), .rst(rst), .clr(ctrl_q[0]), .push(tx_push), .wdata(s_wb_data_i[DB-1:0]),
        .pop(tx_launch), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    wb_classic_uart_fifo #(.WIDTH(DB), .DEPTH(16)) u_rx_fifo (
        .clk(clk), .rst(rst), .clr(ctrl_q[1]), .push(rx_push), .wdata(rx_shift_q),
        .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    assign tx_tick_raw = (tx_state_q != S_IDLE) && (tx_cnt_q == 16'(BIT_PERIOD - 1));
    assign rx_tick_raw = (rx_state_q == S_START) ? (rx_cnt_q == 16'(HALF_PERIOD - 1))
                       : ((rx_state_q != S_IDLE) && (rx_cnt_q == 16'(BIT_PERIOD - 1)));

    wb_classic_uart_dly #(.STAGES(TX_BAUD_DELAY), .RST_VAL(1'b0)) u_tx_tick (
        .clk(clk), .rst(rst), .d(tx_tick_raw), .q(tx_tick));
    wb_classic_uart_dly #(.STAGES(RX_BAUD_DELAY), .RST_VAL(1'b0)) u_rx_tick (
        .clk(clk), .rst(rst), .d(rx_tick_raw), .q(rx_tick));
    wb_classic_uart_dly #(.STAGES(RX_DELAY), .RST_VAL(1'b1)) u_rx_dly (
        .clk(clk), .rst(rst), .d(rx_sync_q), .q(rx_in));
    wb_classic_uart_dly #(.STAGES(TX_DELAY), .RST_VAL(1'b1)) u_tx_dly (
        .clk(clk), .rst(rst), .d(tx_line_q), .q(tx));

    assign status = {24'd0, parity_q, frame_q, overrun_q, 1'b0, tx_full, tx_empty, rx_full, !rx_empty};

    // Side effects happen on the request edge; control resets are held one cycle so they land after ack.
    always_comb begin
        req       = s_wb_cyc && s_wb_stb && !ack_q;
        ack_d     = req;
        dat_d     = '0;
        ctrl_d    = '0;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        status_rd = 1'b0;
        if (req) begin
            case (s_wb_addr[3:2])
                2'd0: if (!s_wb_we && !rx_empty) begin
                    rx_pop = 1'b1;
                    dat_d  = 32'(rx_rdata);
                end
                2'd1: tx_push = s_wb_we;
                2'd2: if (!s_wb_we) begin
                    status_rd = 1'b1;
                    dat_d     = status;
                end
                default: if (s_wb_we) ctrl_d = s_wb_data_i[1:0];
            endcase
        end
        overrun_d = (overrun_q && !status_rd) || (rx_push && rx_full && !rx_pop);
        frame_d   = (frame_q && !status_rd) || (rx_push && !rx_in);
        parity_d  = (parity_q && !status_rd) || (rx_push && rx_par_bad_q);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_state_q == S_IDLE || tx_tick_raw) ? 16'd0 : tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_launch  = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_line_d = 1'b1;
                tx_launch = !tx_empty && cts;
            end
            S_START: if (tx_tick) begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
                tx_line_d  = tx_shift_q[0];
            end
            S_DATA: if (tx_tick) begin
                if (tx_bit_q == 3'(DB - 1)) begin
                    tx_state_d = (PARITY_ENA != 0) ? S_PARITY : S_STOP;
                    tx_line_d  = (PARITY_ENA != 0) ? tx_par_q : 1'b1;
                    tx_stop_d  = 1'b0;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_line_d  = tx_shift_q[1];
                end
            end
            S_PARITY: if (tx_tick) begin
                tx_state_d = S_STOP;
                tx_line_d  = 1'b1;
                tx_stop_d  = 1'b0;
            end
            S_STOP: if (tx_tick) begin
                if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                    tx_state_d = S_IDLE;
                    tx_line_d  = 1'b1;
                    tx_launch  = !tx_empty && cts;
                end else begin
                    tx_stop_d = 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_launch) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_rdata;
            tx_par_d   = (^tx_rdata) ^ (PARITY_TYPE != 0);
            tx_line_d  = 1'b0;
        end
    end

    always_comb begin
        rx_meta_d    = rx;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_in;
        rx_state_d   = rx_state_q;
        rx_cnt_d     = (rx_state_q == S_IDLE || rx_tick_raw) ? 16'd0 : rx_cnt_q + 16'd1;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_push      = 1'b0;
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_in) begin
                rx_state_d   = S_START;
                rx_par_bad_d = 1'b0;
            end
            S_START: if (rx_tick) begin
                rx_state_d = rx_in ? S_IDLE : S_DATA;
                rx_bit_d   = '0;
            end
            S_DATA: if (rx_tick) begin
                rx_shift_d = {rx_in, rx_shift_q[DB-1:1]};
                if (rx_bit_q == 3'(DB - 1)) rx_state_d = (PARITY_ENA != 0) ? S_PARITY : S_STOP;
                else                        rx_bit_d   = rx_bit_q + 3'd1;
            end
            S_PARITY: if (rx_tick) begin
                rx_par_bad_d = rx_in ^ (^rx_shift_q) ^ (PARITY_TYPE != 0);
                rx_state_d   = S_STOP;
            end
            S_STOP: if (rx_tick) begin
                rx_push    = 1'b1;
                rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            ctrl_q       <= '0;
            overrun_q    <= 1'b0;
            frame_q      <= 1'b0;
            parity_q     <= 1'b0;
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_stop_q    <= 1'b0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            tx_line_q    <= 1'b1;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_bad_q <= 1'b0;
        end else begin
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            ctrl_q       <= ctrl_d;
            overrun_q    <= overrun_d;
            frame_q      <= frame_d;
            parity_q     <= parity_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_stop_q    <= tx_stop_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            tx_line_q    <= tx_line_d;
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_bad_q <= rx_par_bad_d;
        end
    end

    assign s_wb_ack    = ack_q;
    assign s_wb_data_o = dat_q;
    assign rts         = !rx_full;
endmodule

// File: tb/tb_wb_classic_uart.sv
// Directed bench for wb_classic_uart: reset, bus handshake, loopback, FIFO overflow, RX errors, control.
// Baud is scaled to 16 clocks per bit so the long multi-frame scenarios stay short.

module tb_wb_classic_uart;
    localparam int P = 16;

    logic        clk = 1'b0;
    logic        rst, s_wb_cyc, s_wb_stb, s_wb_we, s_wb_ack, tx, rx, rts, cts;
    logic [15:0] s_wb_addr;
    logic [31:0] s_wb_data_i, s_wb_data_o, rd;
    logic [3:0]  s_wb_sel;
    logic        loop, rx_drv;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    wb_classic_uart #(.BAUD_CLOCK_SPEED(1600000), .BAUD_RATE(100000)) dut (
        .clk(clk), .rst(rst), .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
        .s_wb_addr(s_wb_addr), .s_wb_data_i(s_wb_data_i), .s_wb_sel(s_wb_sel),
        .s_wb_ack(s_wb_ack), .s_wb_data_o(s_wb_data_o), .tx(tx), .rx(rx), .rts(rts), .cts(cts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns one cycle after the ack has been sampled.
    task automatic wb_xfer(input logic we_i, input logic [15:0] addr_i, input logic [31:0] wdata_i,
                           output logic [31:0] rdata_o);
        int n;
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = we_i;
        s_wb_addr = addr_i; s_wb_data_i = wdata_i;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!s_wb_ack && n < 8);
        check("ack_seen", 32'(s_wb_ack), 32'd1);
        rdata_o = s_wb_data_o;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        step(1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        step(P);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            step(P);
        end
        rx_drv = stop_bit;
        step(P);
        rx_drv = 1'b1;
    endtask

    initial begin
        rst = 1'b0; loop = 1'b1; rx_drv = 1'b1; cts = 1'b1;
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        s_wb_addr = '0; s_wb_data_i = '0; s_wb_sel = 4'hF;

        // Reset state
        step(25);
        check("rst_ack", 32'(s_wb_ack), 32'd0);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_rts", 32'(rts), 32'd1);
        check("rst_dat", s_wb_data_o, 32'd0);
        rst = 1'b1;
        step(2);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("rst_status", rd, 32'h4);

        // Ack timing, held request; also first loopback byte
        s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
        s_wb_addr = 16'h4; s_wb_data_i = 32'hAAAA0000;
        step(1);
        check("ack_one_clk", 32'(s_wb_ack), 32'd1);
        step(1);
        check("ack_not_twice", 32'(s_wb_ack), 32'd0);
        check("tx_start_bit", 32'(tx), 32'd0);
        s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        check("dat_idle", s_wb_data_o, 32'd0);
        step(1);

        // Loopback of two bytes
        wb_xfer(1'b1, 16'h4, 32'hAAAA0001, rd);
        step(400);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("lb_status", rd, 32'h5);
        wb_xfer(1'b0, 16'h0, '0, rd);
        check("lb_rx0", rd, 32'h00);
        wb_xfer(1'b0, 16'h0, '0, rd);
        check("lb_rx1", rd, 32'h01);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("lb_empty", rd, 32'h4);
        wb_xfer(1'b0, 16'h0, '0, rd);
        check("rx_empty_read", rd, 32'h0);
        wb_xfer(1'b0, 16'h4, '0, rd);
        check("tx_reg_read", rd, 32'h0);

        // TX overflow with cts held low, then release
        cts = 1'b0;
        for (int i = 0; i < 17; i++) wb_xfer(1'b1, 16'h4, 32'hAAAA0010 + 32'(i), rd);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("tx_full_status", rd, 32'h8);
        cts = 1'b1;
        step(2700);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("ovf_rx_status", rd, 32'h7);
        check("ovf_rts", 32'(rts), 32'd0);
        for (int i = 0; i < 16; i++) begin
            wb_xfer(1'b0, 16'h0, '0, rd);
            check("ovf_rx_byte", rd, 32'h10 + 32'(i));
        end
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("ovf_drained", rd, 32'h4);

        // Frame error with one TX byte parked (cts low)
        loop = 1'b0;
        cts = 1'b0;
        wb_xfer(1'b1, 16'h4, 32'h77, rd);
        send_frame(8'h5A, 1'b0);
        step(10);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("frame_err_1st", rd, 32'h41);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("frame_err_2nd", rd, 32'h01);
        wb_xfer(1'b0, 16'h0, '0, rd);
        check("frame_err_byte", rd, 32'h5A);

        // RX overrun with 17 frames
        for (int i = 0; i < 17; i++) send_frame(8'h30 + 8'(i), 1'b1);
        step(20);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("overrun_status", rd, 32'h23);
        check("overrun_rts", 32'(rts), 32'd0);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("overrun_cleared", rd, 32'h03);
        wb_xfer(1'b0, 16'h0, '0, rd);
        check("overrun_head", rd, 32'h30);

        // Control: reset both FIFOs with data queued
        wb_xfer(1'b1, 16'hC, 32'h3, rd);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("ctrl_status", rd, 32'h4);
        check("ctrl_rts", 32'(rts), 32'd1);

        // Reset mid-frame
        cts = 1'b1;
        wb_xfer(1'b1, 16'h4, 32'hAAAA0000, rd);
        step(40);
        check("midframe_tx_low", 32'(tx), 32'd0);
        rst = 1'b0;
        step(1);
        check("midframe_tx_high", 32'(tx), 32'd1);
        step(3);
        rst = 1'b1;
        step(2);
        wb_xfer(1'b0, 16'h8, '0, rd);
        check("post_rst_status", rd, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
